// File: rtl/layer1_input_packer.sv
// Beat-to-vector packer feeding the layer-1 LUT array: assembles BEATS narrow beats
// into one registered vector, double-buffered, with s_last framing checks.
module layer1_input_packer #(
    parameter int unsigned BEAT_W = 8,
    parameter int unsigned BEATS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BEAT_W-1:0]        s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [BEAT_W*BEATS-1:0]  m_vec,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     err_pulse,
    output logic [7:0]               err_cnt
);

    localparam int unsigned VEC_W = BEAT_W * BEATS;
    localparam int unsigned CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   asm_q, asm_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               valid_q, valid_d;
    logic               pulse_q, pulse_d;
    logic [7:0]         errcnt_q, errcnt_d;

    logic               accept;
    logic               slot_free;
    logic               last_beat;
    logic               frame_err;
    logic [VEC_W-1:0]   asm_ins;

    assign s_ready   = rst && (state_q != HOLD);
    assign accept    = s_valid && s_ready;
    assign slot_free = !valid_q || m_ready;
    assign last_beat = (cnt_q == LAST_IDX);

    always_comb begin
        asm_ins = asm_q;
        asm_ins[cnt_q*BEAT_W +: BEAT_W] = s_data;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        vec_d     = vec_q;
        valid_d   = valid_q && !m_ready;
        frame_err = 1'b0;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (last_beat && s_last) begin
                        cnt_d = '0;
                        if (slot_free) begin
                            vec_d   = asm_ins;
                            valid_d = 1'b1;
                            asm_d   = '0;
                        end else begin
                            // cnt is reset now; HOLD only transfers and never reads it
                            asm_d   = asm_ins;
                            state_d = HOLD;
                        end
                    end else if (last_beat) begin
                        frame_err = 1'b1;
                        asm_d     = '0;
                        cnt_d     = '0;
                        state_d   = DROP;
                    end else if (s_last) begin
                        frame_err = 1'b1;
                        asm_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        asm_d = asm_ins;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    vec_d   = asm_q;
                    valid_d = 1'b1;
                    asm_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
                asm_d   = '0;
            end
        endcase

        pulse_d  = frame_err;
        errcnt_d = errcnt_q;
        if (frame_err && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            asm_q    <= '0;
            vec_q    <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            vec_q    <= vec_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign m_vec     = vec_q;
    assign m_valid   = valid_q;
    assign err_pulse = pulse_q;
    assign err_cnt   = errcnt_q;

endmodule

// File: tb/tb_layer1_input_packer.sv
// Self-checking bench for layer1_input_packer: directed scenarios plus randomized
// traffic against a queue-based transaction model.
module tb_layer1_input_packer;

    localparam int BEAT_W = 8;
    localparam int BEATS  = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] m_vec;
    logic        m_valid;
    logic        m_ready;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int errors;
    int checks;

    // Reference model: beats gathered so far, plus drop/hold flags and expected outputs
    logic [7:0]  q_frag[$];
    bit          md_drop;
    bit          md_hold;
    logic [31:0] e_vec;
    bit          e_valid;
    bit          e_pulse;
    int          e_cnt;

    layer1_input_packer #(.BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_vec     (m_vec),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update();
        logic [31:0] v;
        bit free;
        bit load;
        bit pulse;
        if (!rst) begin
            q_frag.delete();
            md_drop = 0; md_hold = 0;
            e_vec = '0; e_valid = 0; e_pulse = 0; e_cnt = 0;
            return;
        end
        free  = !e_valid || m_ready;
        load  = 0;
        pulse = 0;
        if (md_hold) begin
            if (free) begin
                load = 1; md_hold = 0;
            end
        end else if (s_valid) begin
            if (md_drop) begin
                if (s_last) md_drop = 0;
            end else begin
                q_frag.push_back(s_data);
                if (q_frag.size() == BEATS) begin
                    if (!s_last) begin
                        pulse = 1; md_drop = 1; q_frag.delete();
                    end else if (free) begin
                        load = 1;
                    end else begin
                        md_hold = 1;
                    end
                end else if (s_last) begin
                    pulse = 1; q_frag.delete();
                end
            end
        end
        if (load) begin
            v = '0;
            foreach (q_frag[k]) v = v | (32'(q_frag[k]) << (8 * k));
            e_vec = v; e_valid = 1;
            q_frag.delete();
        end else if (e_valid && m_ready) begin
            e_valid = 0;
        end
        e_pulse = pulse;
        if (pulse && e_cnt < 255) e_cnt++;
    endtask

    // One clock: inputs are set at the falling edge, outputs read at the next falling edge
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        s_valid = 1'b1; s_data = d; s_last = last;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        tick(); tick();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_vec !== 32'h0) begin errors++; $display("FAIL reset_m_vec got=%h exp=0", m_vec); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
        checks++; if (err_cnt !== 8'h0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", m_valid); end
        send_beat(8'h44, 1'b1);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", m_valid); end
        checks++; if (m_vec !== 32'h44332211) begin errors++; $display("FAIL basic_vec got=%h exp=44332211", m_vec); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL basic_err_cnt got=%0d exp=0", err_cnt); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", m_valid); end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), (i == 4) || (i == 8));
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_s_ready got=%b exp=0", s_ready); end
        checks++; if (m_vec !== 32'h04030201) begin errors++; $display("FAIL b2b_vec_a got=%h exp=04030201", m_vec); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_a got=%b exp=1", m_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_ready !== 1'b0 || m_vec !== 32'h04030201) begin
                errors++; $display("FAIL b2b_stall s_ready=%b vec=%h exp 0/04030201", s_ready, m_vec);
            end
        end
        m_ready = 1'b1;
        tick();
        checks++; if (m_vec !== 32'h08070605) begin errors++; $display("FAIL b2b_vec_b got=%h exp=08070605", m_vec); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_b got=%b exp=1", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got=%b exp=1", s_ready); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_clear got=%b exp=0", m_valid); end
    endtask

    task automatic test_early_last();
        do_reset();
        m_ready = 1'b1;
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL early_pulse got=%b exp=1", err_pulse); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL early_cnt got=%0d exp=1", err_cnt); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL early_valid got=%b exp=0", m_valid); end
        tick();
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL early_pulse_width got=%b exp=0", err_pulse); end
        for (int i = 0; i < 4; i++) send_beat(8'(8'h0A + i), i == 3);
        checks++; if (m_valid !== 1'b1 || m_vec !== 32'h0D0C0B0A) begin
            errors++; $display("FAIL early_next_vec valid=%b vec=%h exp 1/0D0C0B0A", m_valid, m_vec);
        end
    endtask

    task automatic test_missing_last();
        int pulses;
        do_reset();
        m_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            send_beat(8'(8'h50 + i), i == 5);
            if (err_pulse === 1'b1) pulses++;
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL missing_no_output beat=%0d got=%b exp=0", i, m_valid); end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL missing_pulses got=%0d exp=1", pulses); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL missing_cnt got=%0d exp=1", err_cnt); end
        for (int i = 0; i < 4; i++) send_beat(8'(8'h31 + i), i == 3);
        checks++; if (m_valid !== 1'b1 || m_vec !== 32'h34333231) begin
            errors++; $display("FAIL missing_next_vec valid=%b vec=%h exp 1/34333231", m_valid, m_vec);
        end
    endtask

    task automatic test_reset_mid_fill();
        m_ready = 1'b1;
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        rst = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready got=%b exp=0", s_ready); end
        tick();
        checks++; if (m_valid !== 1'b0 || m_vec !== 32'h0 || err_pulse !== 1'b0 || err_cnt !== 8'h0) begin
            errors++; $display("FAIL midrst_outputs valid=%b vec=%h pulse=%b cnt=%0d exp all 0", m_valid, m_vec, err_pulse, err_cnt);
        end
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) send_beat(8'(i), i == 4);
        checks++; if (m_vec !== 32'h04030201) begin errors++; $display("FAIL midrst_vec got=%h exp=04030201", m_vec); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            send_beat(8'(i), 1'b1);
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            checks++; if (err_pulse !== 1'b1 || err_cnt !== 8'(exp_cnt)) begin
                errors++; $display("FAIL sat_err n=%0d pulse=%b cnt=%0d exp 1/%0d", i, err_pulse, err_cnt, exp_cnt);
            end
        end
        tick();
        checks++; if (err_pulse !== 1'b0 || err_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_final pulse=%b cnt=%0d exp 0/255", err_pulse, err_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst     = ($urandom_range(0, 199) != 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            if (!md_drop && q_frag.size() == BEATS - 1) s_last = ($urandom_range(0, 9) != 0);
            else s_last = ($urandom_range(0, 19) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++; if (s_ready !== (rst && !md_hold)) begin
                errors++; $display("FAIL rand_s_ready cyc=%0d got=%b exp=%b", c, s_ready, rst && !md_hold);
            end
            tick();
            checks++; if (m_valid !== e_valid || m_vec !== e_vec || err_pulse !== e_pulse || err_cnt !== 8'(e_cnt)) begin
                errors++;
                $display("FAIL rand_out cyc=%0d valid=%b vec=%h pulse=%b cnt=%0d exp %b/%h/%b/%0d",
                         c, m_valid, m_vec, err_pulse, err_cnt, e_valid, e_vec, e_pulse, e_cnt);
            end
        end
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        md_drop = 0; md_hold = 0; e_vec = '0; e_valid = 0; e_pulse = 0; e_cnt = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_early_last();
        test_missing_last();
        test_reset_mid_fill();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
